// File: rtl/vme_system_controller_pkg.sv
// Shared definitions for the slot-1 VME system controller: signal polarity,
// arbiter state encoding, request levels and level-selection helpers.
package vme_defs;

    localparam logic ACTIVE     = 1'b0;
    localparam logic INACTIVE   = 1'b1;
    localparam int   NUM_LEVELS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        LVL_BR0 = 2'd0,
        LVL_BR1 = 2'd1,
        LVL_BR2 = 2'd2,
        LVL_BR3 = 2'd3
    } level_t;

    // req is active-high here; the highest set bit wins
    function automatic logic [1:0] pick_fixed(input logic [3:0] req);
        logic [1:0] lvl;
        lvl = LVL_BR0;
        for (int i = 0; i < NUM_LEVELS; i++)
            if (req[i]) lvl = 2'(i);
        return lvl;
    endfunction

    // First active level scanning upward from last+1, wrapping back to last
    function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] lvl;
        logic [1:0] idx;
        lvl = last;
        for (int k = NUM_LEVELS; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) lvl = idx;
        end
        return lvl;
    endfunction

    function automatic logic above_level(input logic [3:0] req, input logic [1:0] lvl);
        return |(req & (4'b1110 << lvl));
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous bit; resets to the idle level.
module sync2
    import vme_defs::*;
#(
    parameter logic RESET_VAL = INACTIVE
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/vme_system_controller_bus_timer.sv
// Global bus timer: drives BERR when a data strobe stays unacknowledged for
// BUS_TIMEOUT cycles, and pulses timeout_flag once per expiry.
module vme_bus_timer
    import vme_defs::*;
#(
    parameter int BUS_TIMEOUT = 256,
    parameter int TIMER_WIDTH = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic strobe,
    input  logic dtack,
    input  logic berr_in,
    input  logic ds_idle,
    output logic berr_out,
    output logic timeout_flag
);
    localparam logic [TIMER_WIDTH-1:0] TERMINAL = TIMER_WIDTH'(BUS_TIMEOUT - 1);

    logic [TIMER_WIDTH-1:0] count;
    logic                   acked;
    logic                   fire;

    // An acknowledge seen on the terminal cycle suppresses the expiry
    assign acked = dtack || berr_in;
    assign fire  = strobe && !acked && (berr_out == INACTIVE) && (count == TERMINAL);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count        <= '0;
            berr_out     <= INACTIVE;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= fire;
            if (!strobe || acked)
                count <= '0;
            else if ((berr_out == INACTIVE) && (count != '1))
                count <= count + 1'b1;

            if (fire)
                berr_out <= ACTIVE;
            else if (ds_idle)
                berr_out <= INACTIVE;
        end
    end
endmodule

// File: rtl/vme_system_controller.sv
// Slot-1 VME system controller: four-level bus arbiter driving the BGxIN
// chains and BCLR, plus the global bus timer. All VME pins are active-low.
module vme_system_controller
    import vme_defs::*;
#(
    parameter int ROUND_ROBIN   = 0,
    parameter int GRANT_TIMEOUT = 32,
    parameter int BUS_TIMEOUT   = 256,
    parameter int TIMER_WIDTH   = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] vme_bus_request,
    input  logic       vme_bus_busy,
    output logic [3:0] vme_bus_grant_out,
    output logic       vme_bus_clear,
    input  logic       vme_as,
    input  logic [1:0] vme_ds,
    input  logic       vme_dtack,
    input  logic       vme_berr_in,
    output logic       vme_berr_out,
    output logic       timeout_flag
);
    localparam int NUM_SYNC = 10;
    localparam logic [TIMER_WIDTH-1:0] GRANT_LOAD = TIMER_WIDTH'(GRANT_TIMEOUT - 1);

    logic [NUM_SYNC-1:0] raw;
    logic [NUM_SYNC-1:0] synced;

    assign raw = {vme_berr_in, vme_dtack, vme_ds, vme_as, vme_bus_busy, vme_bus_request};

    for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
        sync2 #(.RESET_VAL(INACTIVE)) u_sync (
            .clock (clock),
            .reset (reset),
            .d     (raw[i]),
            .q     (synced[i])
        );
    end

    logic [3:0] req;
    logic       busy;
    logic       ds_idle;
    logic       strobe;

    assign req     = ~synced[3:0];
    assign busy    = (synced[4] == ACTIVE);
    assign ds_idle = (synced[7:6] == {2{INACTIVE}});
    assign strobe  = (synced[5] == ACTIVE) && !ds_idle;

    arb_state_t             state, state_nx;
    logic [1:0]             level, level_nx;
    logic [1:0]             ptr, ptr_nx;
    logic [TIMER_WIDTH-1:0] gcnt, gcnt_nx;
    logic [3:0]             grant_nx;
    logic                   clear_nx;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= ARB_IDLE;
            level             <= LVL_BR0;
            ptr               <= LVL_BR0;
            gcnt              <= '0;
            vme_bus_grant_out <= {4{INACTIVE}};
            vme_bus_clear     <= INACTIVE;
        end else begin
            state             <= state_nx;
            level             <= level_nx;
            ptr               <= ptr_nx;
            gcnt              <= gcnt_nx;
            vme_bus_grant_out <= grant_nx;
            vme_bus_clear     <= clear_nx;
        end
    end

    always_comb begin
        state_nx = state;
        level_nx = level;
        ptr_nx   = ptr;
        gcnt_nx  = gcnt;
        case (state)
            ARB_IDLE: begin
                if ((|req) && !busy) begin
                    state_nx = ARB_GRANT;
                    level_nx = (ROUND_ROBIN != 0) ? pick_rr(req, ptr) : pick_fixed(req);
                    gcnt_nx  = GRANT_LOAD;
                end
            end
            ARB_GRANT: begin
                if (busy)
                    state_nx = ARB_BUSY;
                else if (gcnt == '0)
                    state_nx = ARB_RELEASE;
                else
                    gcnt_nx = gcnt - 1'b1;
            end
            ARB_BUSY: begin
                if (!busy) begin
                    state_nx = ARB_RELEASE;
                    if (ROUND_ROBIN != 0) ptr_nx = level;
                end
            end
            ARB_RELEASE: state_nx = ARB_IDLE;
            default:     state_nx = ARB_IDLE;
        endcase

        // Outputs are registered from the next state so they change on the transition edge
        grant_nx = {4{INACTIVE}};
        if (state_nx == ARB_GRANT) grant_nx[level_nx] = ACTIVE;

        clear_nx = INACTIVE;
        if ((state_nx == ARB_BUSY) && (ROUND_ROBIN == 0) && above_level(req, level_nx))
            clear_nx = ACTIVE;
    end

    vme_bus_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_bus_timer (
        .clock        (clock),
        .reset        (reset),
        .strobe       (strobe),
        .dtack        (synced[8] == ACTIVE),
        .berr_in      (synced[9] == ACTIVE),
        .ds_idle      (ds_idle),
        .berr_out     (vme_berr_out),
        .timeout_flag (timeout_flag)
    );
endmodule

// File: tb/tb_vme_system_controller.sv
// Directed and randomized checks of the VME system controller: one fixed-priority
// instance (arbiter + bus timer) and one round-robin instance (arbiter only).
module tb_vme_system_controller;
    localparam int GT = 32;
    localparam int BT = 256;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] f_br  = 4'hF;
    logic       f_bbsy = 1'b1;
    logic       as_n   = 1'b1;
    logic [1:0] ds_n   = 2'b11;
    logic       dtack_n = 1'b1;
    logic       berr_in_n = 1'b1;
    logic [3:0] f_bg;
    logic       f_clr, f_berr, f_flag;

    logic [3:0] r_br  = 4'hF;
    logic       r_bbsy = 1'b1;
    logic [3:0] r_bg;
    logic       r_clr, r_berr, r_flag;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    vme_system_controller #(.ROUND_ROBIN(0), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT), .TIMER_WIDTH(9)) dut_fixed (
        .clock (clock), .reset (reset),
        .vme_bus_request (f_br), .vme_bus_busy (f_bbsy),
        .vme_bus_grant_out (f_bg), .vme_bus_clear (f_clr),
        .vme_as (as_n), .vme_ds (ds_n), .vme_dtack (dtack_n), .vme_berr_in (berr_in_n),
        .vme_berr_out (f_berr), .timeout_flag (f_flag)
    );

    vme_system_controller #(.ROUND_ROBIN(1), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT), .TIMER_WIDTH(9)) dut_rr (
        .clock (clock), .reset (reset),
        .vme_bus_request (r_br), .vme_bus_busy (r_bbsy),
        .vme_bus_grant_out (r_bg), .vme_bus_clear (r_clr),
        .vme_as (1'b1), .vme_ds (2'b11), .vme_dtack (1'b1), .vme_berr_in (1'b1),
        .vme_berr_out (r_berr), .timeout_flag (r_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Model: the grant vector for a tenure owned by level lvl
    function automatic logic [3:0] grant_vec(input int lvl);
        logic [3:0] g;
        g = 4'hF;
        g[lvl] = 1'b0;
        return g;
    endfunction

    function automatic int highest(input logic [3:0] act);
        int h;
        h = -1;
        for (int i = 0; i < 4; i++) if (act[i]) h = i;
        return h;
    endfunction

    function automatic int rr_next(input logic [3:0] act, input int last);
        for (int i = 1; i <= 4; i++)
            if (act[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    function automatic int low_count(input logic [3:0] g);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) if (g[i] == 1'b0) c++;
        return c;
    endfunction

    // One strobe with an optional acknowledge at tick ack_at (0 = none); returns BERR/flag statistics
    task automatic strobe_run(input int ack_at, input bit use_berr_in,
                              output int first_low, output int low_ticks,
                              output int flag_ticks, output int flag_at);
        first_low = -1; low_ticks = 0; flag_ticks = 0; flag_at = -1;
        as_n = 1'b0;
        ds_n = 2'b10;
        for (int t = 1; t <= BT + 10; t++) begin
            if (t - 1 == ack_at && ack_at > 0) begin
                if (use_berr_in) berr_in_n = 1'b0;
                else dtack_n = 1'b0;
            end
            tick();
            if (f_berr == 1'b0) begin
                low_ticks++;
                if (first_low < 0) first_low = t;
            end
            if (f_flag == 1'b1) begin
                flag_ticks++;
                if (flag_at < 0) flag_at = t;
            end
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] pat;
        logic [3:0] rr_pat;
        int lvl, exp_lvl, rr_last, cnt, bound;
        int first_low, low_ticks, flag_ticks, flag_at;
        int ack_list[4];

        // Reset state
        ticks(3);
        chk("reset_bg", f_bg, 4'hF);
        chk("reset_bclr", f_clr, 1'b1);
        chk("reset_berr", f_berr, 1'b1);
        chk("reset_flag", f_flag, 1'b0);
        chk("reset_rr_bg", r_bg, 4'hF);
        reset = 1'b1;
        ticks(2);

        // Single request on BR2
        f_br = 4'b1011;
        ticks(2);
        chk("single_latency_bg", f_bg, 4'hF);
        tick();
        chk("single_grant_bg2", f_bg, grant_vec(2));
        f_bbsy = 1'b0;
        f_br   = 4'hF;
        ticks(2);
        chk("single_hold_bg2", f_bg, grant_vec(2));
        tick();
        chk("single_busy_bg", f_bg, 4'hF);
        chk("single_busy_bclr", f_clr, 1'b1);
        // BBSY release and a new request together: RELEASE and IDLE come first
        f_bbsy = 1'b1;
        f_br   = 4'b1110;
        ticks(4);
        chk("release_gap_bg", f_bg, 4'hF);
        tick();
        chk("release_regrant_bg0", f_bg, grant_vec(0));
        f_bbsy = 1'b0;
        f_br   = 4'hF;
        ticks(3);
        f_bbsy = 1'b1;
        ticks(5);

        // Fixed priority with random request patterns
        for (int it = 0; it < 6; it++) begin
            pat  = 4'($urandom_range(1, 15));
            f_br = ~pat;
            ticks(2);
            chk("fixed_latency_bg", f_bg, 4'hF);
            tick();
            chk("fixed_grant", f_bg, grant_vec(highest(pat)));
            f_bbsy = 1'b0;
            f_br   = 4'hF;
            ticks(3);
            chk("fixed_busy_bg", f_bg, 4'hF);
            f_bbsy = 1'b1;
            ticks(5);
        end

        // BR0+BR3 together, then pre-emption of a level-1 tenure
        f_br = 4'b0110;
        ticks(3);
        chk("prio_br3_over_br0", f_bg, 4'b0111);
        f_bbsy = 1'b0;
        f_br   = 4'hF;
        ticks(3);
        f_bbsy = 1'b1;
        ticks(5);
        f_br = 4'b1101;
        ticks(3);
        chk("owner1_grant", f_bg, grant_vec(1));
        f_bbsy = 1'b0;
        f_br   = 4'hF;
        ticks(3);
        chk("owner1_bclr_idle", f_clr, 1'b1);
        f_br = 4'b1110;
        ticks(3);
        chk("lower_req_no_bclr", f_clr, 1'b1);
        f_br = 4'b0110;
        ticks(2);
        chk("preempt_bclr_latency", f_clr, 1'b1);
        tick();
        chk("preempt_bclr_asserted", f_clr, 1'b0);
        chk("preempt_bg_high", f_bg, 4'hF);
        f_br = 4'b1110;
        ticks(3);
        chk("preempt_bclr_released", f_clr, 1'b1);
        f_br = 4'hF;
        ticks(3);
        f_bbsy = 1'b1;
        ticks(5);

        // Round robin: four requesters give 1,2,3,0,1, then random subsets
        rr_pat  = 4'hF;
        r_br    = ~rr_pat;
        rr_last = 0;
        for (int t = 0; t < 9; t++) begin
            exp_lvl = rr_next(rr_pat, rr_last);
            bound = 0;
            while (r_bg == 4'hF && bound < 12) begin
                tick();
                bound++;
            end
            chk("rr_grant_seen", (r_bg != 4'hF), 1'b1);
            chk("rr_one_grant", low_count(r_bg), 1);
            lvl = -1;
            for (int i = 3; i >= 0; i--) if (r_bg[i] == 1'b0) lvl = i;
            chk("rr_grant_level", lvl, exp_lvl);
            rr_last = exp_lvl;
            r_bbsy = 1'b0;
            ticks(3);
            chk("rr_busy_bg", r_bg, 4'hF);
            chk("rr_never_bclr", r_clr, 1'b1);
            if (t >= 4) rr_pat = 4'($urandom_range(1, 15));
            r_br   = ~rr_pat;
            r_bbsy = 1'b1;
            tick();
        end
        r_br = 4'hF;
        ticks(GT + 10);
        chk("rr_idle_bg", r_bg, 4'hF);

        // Grant timeout with a retained BR1
        f_br = 4'b1101;
        ticks(3);
        chk("timeout_grant_bg1", f_bg, grant_vec(1));
        cnt = 1;
        while (f_bg == grant_vec(1) && cnt < GT + 20) begin
            tick();
            if (f_bg == grant_vec(1)) cnt++;
        end
        chk("timeout_low_cycles", cnt, GT);
        cnt = 0;
        while (f_bg == 4'hF && cnt < 10) begin
            cnt++;
            tick();
        end
        chk("timeout_high_gap", cnt, 2);
        chk("timeout_regrant_bg1", f_bg, grant_vec(1));
        f_br = 4'hF;
        ticks(GT + 10);
        chk("timeout_idle_bg", f_bg, 4'hF);

        // Bus timer expiry with no acknowledge
        strobe_run(0, 1'b0, first_low, low_ticks, flag_ticks, flag_at);
        chk("expiry_first_berr", first_low, BT + 2);
        chk("expiry_flag_at", flag_at, BT + 2);
        chk("expiry_flag_pulses", flag_ticks, 1);
        chk("expiry_berr_held", low_ticks, 9);
        as_n = 1'b1;
        ds_n = 2'b11;
        ticks(3);
        chk("expiry_berr_released", f_berr, 1'b1);
        ticks(3);

        // Acknowledge timing: early, on the terminal cycle, one cycle late, random
        ack_list[0] = BT - 10;
        ack_list[1] = BT - 1;
        ack_list[2] = BT;
        ack_list[3] = $urandom_range(1, BT - 2);
        for (int k = 0; k < 4; k++) begin
            strobe_run(ack_list[k], (k == 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                       first_low, low_ticks, flag_ticks, flag_at);
            chk("ack_berr_ticks", low_ticks, (ack_list[k] >= BT) ? 9 : 0);
            chk("ack_flag_ticks", flag_ticks, (ack_list[k] >= BT) ? 1 : 0);
            as_n = 1'b1;
            ds_n = 2'b11;
            dtack_n = 1'b1;
            berr_in_n = 1'b1;
            ticks(4);
            chk("ack_berr_idle", f_berr, 1'b1);
        end

        // Reset while granting and while the bus timer counts
        as_n = 1'b0;
        ds_n = 2'b01;
        ticks(20);
        f_br = 4'b1110;
        ticks(3);
        chk("midreset_pre_bg0", f_bg, grant_vec(0));
        reset = 1'b0;
        tick();
        chk("midreset_bg", f_bg, 4'hF);
        chk("midreset_bclr", f_clr, 1'b1);
        chk("midreset_berr", f_berr, 1'b1);
        chk("midreset_flag", f_flag, 1'b0);
        f_br = 4'hF;
        as_n = 1'b1;
        ds_n = 2'b11;
        ticks(2);
        reset = 1'b1;
        low_ticks = 0;
        flag_ticks = 0;
        for (int t = 0; t < BT + 20; t++) begin
            tick();
            if (f_berr == 1'b0) low_ticks++;
            if (f_flag == 1'b1) flag_ticks++;
        end
        chk("postreset_no_berr", low_ticks, 0);
        chk("postreset_no_flag", flag_ticks, 0);
        chk("postreset_bg", f_bg, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
